// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: accepts a word, steps the "1010" detector through windows 0..4,
// accumulates a match mask/count and offers the result on a valid/ready port.
`default_nettype none
`timescale 1ns/1ps

module pattern_scan_ctrl #(
  parameter bit FIRST_ONLY = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [2:0] det_sel,
  output logic [7:0] det_word,
  input  logic [7:0] det_match,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_mask,
  output logic [2:0] res_count,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  logic [2:0] r_win;
  logic [7:0] r_word;
  logic [4:0] r_mask;
  logic [2:0] r_count;

  logic [2:0] w_bit_idx;
  logic       w_hit;

  // Window w reports on det_match bit (4-w); every other bit is treated as noise.
  assign w_bit_idx = 3'd4 - r_win;
  assign w_hit     = det_match[w_bit_idx];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_win   <= 3'd0;
      r_word  <= 8'h00;
      r_mask  <= 5'd0;
      r_count <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_word  <= in_data;
            r_win   <= 3'd0;
            r_mask  <= 5'd0;
            r_count <= 3'd0;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_hit) begin
            r_mask[w_bit_idx] <= 1'b1;
            r_count           <= r_count + 3'd1;
          end
          // r_win returns to 0 on exit so det_sel reads 0 outside SCAN.
          if ((r_win == 3'd4) || (FIRST_ONLY && w_hit)) begin
            r_win   <= 3'd0;
            r_state <= S_DONE;
          end else begin
            r_win <= r_win + 3'd1;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !reset;
  assign det_sel   = r_win;
  assign det_word  = r_word;
  assign res_valid = (r_state == S_DONE);
  assign res_mask  = {3'b000, r_mask};
  assign res_count = r_count;
  assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Sequencing controller for the combinational nibble-window "1010" detector. It accepts one 8-bit word per valid/ready handshake and steps the detector's window select through positions 0..4, one per cycle. It accumulates the per-window match bits into a 5-bit position mask and a match count, then presents the result on a valid/ready output port. It sits between an upstream word source and the result consumer, and owns the detector's select and data inputs exclusively.

## Interface
- FIRST_ONLY, 0, 1 = stop scanning at the first matching window; 0 = scan all five windows.
- clock  in  1  single clock, rising-edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  upstream word valid.
- in_data  in  8  upstream word.
- in_ready  out  1  high only in IDLE while reset is low.
- det_sel  out  3  window select to the detector: 0..4 in SCAN, 0 otherwise.
- det_word  out  8  captured word driven to the detector; holds the last captured value.
- det_match  in  8  detector output, one-hot or zero.
- res_valid  out  1  result valid; high in DONE.
- res_ready  in  1  consumer ready.
- res_mask  out  8  bits [4:0] = matched windows (bit 4-w set means window w matched); bits [7:5] = 0.
- res_count  out  3  number of matched windows, 0..5.
- busy  out  1  high in SCAN or DONE.

## Operation
- Detector contract: for select w in 0..4, det_match bit (4-w) is set iff det_word[7-w:4-w] == 4'b1010, and all other bits are 0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready: capture in_data into det_word, clear the window counter, mask and count, then go to SCAN.
  - SCAN: det_sel = window counter w. Each cycle:
    - Sample only det_match[4-w]; all other det_match bits are ignored.
    - If the sampled bit is 1, set mask bit (4-w) and increment count.
    - If w==4, go to DONE. Else if FIRST_ONLY=1 and the sampled bit is 1, go to DONE. Else w <= w+1.
  - DONE: res_valid=1; res_mask and res_count are held stable. On res_ready, go to IDLE. Backpressure may last indefinitely.
- No pipelining: a new word is accepted only in IDLE. Inputs arriving during SCAN or DONE are not consumed.
- Overlapping matches are counted independently (0xAA yields three matches).
- Arithmetic: count saturates naturally at 5 (3 bits, max 5 windows); the window counter never exceeds 4.

## Timing
- Reset values: state IDLE, det_word 0x00, det_sel 0, res_mask 0x00, res_count 0, res_valid 0, busy 0. in_ready is 0 while reset is high and 1 in the first cycle after reset deasserts.
- Reset mid-SCAN or mid-DONE: at the next edge, return to IDLE with all registers cleared. Any partial result is discarded and res_valid is low the following cycle.
- Latency, full scan: input handshake at edge of cycle N; SCAN occupies cycles N+1..N+5 with det_sel = 0,1,2,3,4; res_valid rises in cycle N+6.
- Latency, FIRST_ONLY early exit: a match at window w gives res_valid in cycle N+2+w.
- DONE to IDLE: a handshake in cycle M (res_valid&&res_ready) puts the block in IDLE at M+1 with res_valid low. A new word may be accepted in cycle M+1.
- Minimum full-scan throughput: one word per 7 cycles.
- res_valid and res_ready both high in the first DONE cycle: the result is consumed in that cycle.

## Test plan
- Reset, then in_data=0xAA, res_ready=1, FIRST_ONLY=0 -> det_sel sequence 0..4; res_mask=0x15, res_count=3; res_valid high exactly in cycle N+6.
- in_data=0x50, then 0x0A, then 0x00 back-to-back -> results 0x08/1, 0x01/1, 0x00/0 in that order; in_ready low throughout each SCAN and DONE.
- FIRST_ONLY=1, in_data=0xAA -> res_mask=0x10, res_count=1, res_valid in cycle N+2. Then in_data=0x0A -> res_mask=0x01, count=1, res_valid in cycle N+6.
- Backpressure: in_data=0xAA, res_ready=0 for 10 cycles while in_valid stays high with 0xFF -> res_mask and res_count stable, 0xFF not accepted until the cycle after res_ready rises.
- Reset asserted during SCAN window 2 -> next cycle IDLE, all outputs at reset values, no res_valid pulse. Then 0xAA -> normal result 0x15/3.
- Detector fault injection: drive det_match=0xFF on every SCAN cycle -> res_mask=0x1F, res_count=5; stray bits are ignored.
